spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//  SPI master that drives the single-wire-command protocol understood by the SPI slave + 256x8 single-port RAM.
//  Accepts one command per request (write addr, write data, read addr, read data) and serialises it on SS_n/MOSI.
//  For read-data commands it also deserialises the returned byte from MISO.
//  Sits between a host/sequencer and the SPI slave wrapper; all signals are in the single clk domain.
// PARAMETERS
//  DATA_WIDTH  8  payload width per frame (address or data byte)
//  MISO_DELAY  2  clk cycles between last command bit and first MISO bit sampled (slave RAM read turnaround), >=1
//  IDLE_GAP    1  clk cycles SS_n is held high after every frame before req_ready re-asserts, >=1
// PORTS
//  clk        in   1           system clock; SPI bit clock is clk itself
//  rst_n      in   1           asynchronous, active-low reset
//  req_valid  in   1           host request strobe
//  req_ready  out  1           master can accept a request
//  req_cmd    in   2           00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA
//  req_data   in   DATA_WIDTH  address/data byte; ignored (sent as 0) for RD_DATA
//  rsp_valid  out  1           one-cycle pulse: rsp_data holds byte read back
//  rsp_data   out  DATA_WIDTH  byte received on MISO, MSB first
//  busy       out  1           high from accept until IDLE_GAP complete
//  SS_n       out  1           slave select, active low
//  MOSI       out  1           serial data to slave
//  MISO       in   1           serial data from slave
// BEHAVIOUR
//  Reset (async assert, sync release): SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0, busy=0, req_ready=1, FSM=IDLE.
//  Handshake: transfer when req_valid & req_ready at posedge; cmd/data registered; req_ready = (state==IDLE).
//   req_valid while not ready is ignored (no queueing).
//  Frame = 1 select bit (=req_cmd[1]) then 10 bits {cmd[1:0], data[7:0]} MSB first; MOSI changes only on posedge.
//  FSM: IDLE -> SELECT -> SHIFT -> (RD_DATA ? WAIT_RD -> RECV : -) -> GAP -> IDLE.
//   Accept at edge N; SELECT cycle N+1: SS_n=0, MOSI=cmd[1].
//   SHIFT cycles N+2..N+11: MOSI = frame[9]..frame[0], 4-bit counter 9->0.
//   Non-RD_DATA: edge N+12 enter GAP, SS_n=1, MOSI=0.
//   RD_DATA: WAIT_RD for MISO_DELAY cycles, SS_n=0, MOSI=0.
//   RD_DATA: RECV for DATA_WIDTH cycles, MISO sampled each posedge into shift reg, MSB first.
//   RD_DATA: after 8th sample: GAP, SS_n=1, rsp_data updated and rsp_valid=1 for exactly that one cycle.
//   GAP: SS_n=1 for IDLE_GAP cycles, busy=1; then IDLE, req_ready=1.
//  SS_n never glitches low outside SELECT/SHIFT/WAIT_RD/RECV; at most one frame per SS_n low period.
//  rsp_data holds last value until next RD_DATA completes; never updated by other commands.
//  Reset mid-frame: SS_n=1 immediately (async); counters/shift regs cleared; no rsp_valid; partial frame discarded.
//  MISO is don't-care outside RECV. X on MISO during RECV propagates to rsp_data (no masking).
//  Back-to-back: earliest next accept is edge after GAP ends; RD_DATA frame length = 11+MISO_DELAY+8 cycles SS_n low.
// TESTING
//  1 Reset: rst_n=0 mid-SHIFT of WR_ADDR 0x3C -> SS_n=1 same cycle, req_ready=1, rsp_valid=0, no further MOSI activity.
//  2 WR_ADDR 0x3C: MOSI over 11 SS_n-low cycles = 0,0,0,0,0,1,1,1,1,0,0; SS_n high at N+12.
//  3 WR_DATA 0xA5 then RD_ADDR 0x3C then RD_DATA -> slave model returns 0xA5; rsp_valid one pulse, rsp_data=0xA5.
//  4 RD_DATA with MISO model 0xFF / 0x00 (MAX/MIN) -> rsp_data=0xFF / 0x00; SS_n low exactly 21 cycles (delay 2).
//  5 req_valid held high continuously with 4 random cmds -> each frame separated by >=IDLE_GAP SS_n-high cycles.
//  5 (cont.) req_ready low throughout each frame; no request lost or duplicated.
//  6 WR_ADDR 0x10 during busy (req_ready=0) -> ignored; MOSI frame of the in-flight request unchanged.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI master for the single-wire-command SPI slave + RAM: serialises one
// command frame per request on SS_n/MOSI and, for RD_DATA, collects the reply byte from MISO.
module spi_master_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MISO_DELAY = 2,
  parameter int IDLE_GAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_cmd,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  SS_n,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int FRAME_W = DATA_WIDTH + 2;
  localparam int M1      = (FRAME_W > MISO_DELAY) ? FRAME_W : MISO_DELAY;
  localparam int M2      = (M1 > DATA_WIDTH) ? M1 : DATA_WIDTH;
  localparam int CNT_MAX = (M2 > IDLE_GAP) ? M2 : IDLE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SHIFT, S_WAIT_RD, S_RECV, S_GAP
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d, rsp_data_q, rsp_data_d, data_sel;
  logic                  rd_q, rd_d, ss_n_q, ss_n_d, mosi_q, mosi_d;
  logic                  rx_en_q, rx_en_d, rsp_valid_q, rsp_valid_d;

  // Pin outputs are registered from the current state, so the wire view
  // trails the FSM by one cycle; rx_en_q realigns MISO sampling to that view.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    rd_d        = rd_q;
    sr_d        = sr_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    ss_n_d      = 1'b1;
    mosi_d      = 1'b0;
    rx_en_d     = (state_q == S_RECV);
    data_sel    = (req_cmd == CMD_RD_DATA) ? {DATA_WIDTH{1'b0}} : req_data;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_SELECT;
          rd_d    = (req_cmd == CMD_RD_DATA);
          frame_d = {req_cmd, data_sel};
        end
      end
      S_SELECT: begin
        ss_n_d  = 1'b0;
        mosi_d  = frame_q[FRAME_W-1];
        cnt_d   = CNT_W'(FRAME_W - 1);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        ss_n_d  = 1'b0;
        mosi_d  = frame_q[FRAME_W-1];
        frame_d = frame_q << 1;
        if (cnt_q == '0) begin
          state_d = rd_q ? S_WAIT_RD : S_GAP;
          cnt_d   = rd_q ? CNT_W'(MISO_DELAY - 1) : CNT_W'(IDLE_GAP - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT_RD: begin
        ss_n_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = S_RECV;
          cnt_d   = CNT_W'(DATA_WIDTH - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RECV: begin
        ss_n_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = CNT_W'(IDLE_GAP - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Last sample lands on the edge where SS_n rises; publish the byte there.
    if (rx_en_q) begin
      sr_d = {sr_q[DATA_WIDTH-2:0], MISO};
      if (state_q != S_RECV) begin
        rsp_data_d  = {sr_q[DATA_WIDTH-2:0], MISO};
        rsp_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      frame_q     <= '0;
      rd_q        <= 1'b0;
      sr_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rx_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      rd_q        <= rd_d;
      sr_q        <= sr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      rx_en_q     <= rx_en_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a negedge monitor captures each SS_n-low frame and
// plays a tiny SPI-RAM slave on MISO; vectors are checked against hand-computed frames.
module tb_spi_master_ctrl;

  localparam int MD  = 2;
  localparam int GAP = 1;
  localparam logic [1:0] WA = 2'b00, WD = 2'b01, RA = 2'b10, RD = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_cmd = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy, SS_n, MOSI;
  logic       MISO = 1'b0;

  spi_master_ctrl #(.DATA_WIDTH(8), .MISO_DELAY(MD), .IDLE_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  // ---------------- monitor + slave model ----------------
  int          frm_len[$];
  logic [31:0] frm_bits[$];
  int          frm_gap[$];
  int          lowcnt = 0, highcnt = 1000, cur_gap = 0, rsp_cnt = 0, bad_ready = 0;
  logic [31:0] shbits = '0;
  logic [7:0]  mem [256];
  logic [7:0]  wr_addr = 8'h00, rd_addr = 8'h00, rd_byte = 8'h00;

  always @(negedge clk) begin
    if (rsp_valid) rsp_cnt++;
    if (!SS_n) begin
      if (lowcnt == 0) begin
        cur_gap = highcnt;
        shbits  = '0;
        rd_byte = mem[rd_addr];
      end
      shbits = {shbits[30:0], MOSI};
      if (lowcnt >= 11 + MD && lowcnt < 19 + MD) MISO = rd_byte[18 + MD - lowcnt];
      else                                       MISO = 1'b0;
      if (req_ready) bad_ready++;
      lowcnt++;
    end else begin
      MISO = 1'b0;
      if (lowcnt != 0) begin
        frm_len.push_back(lowcnt);
        frm_bits.push_back(shbits);
        frm_gap.push_back(cur_gap);
        if (lowcnt == 11) begin
          case (shbits[9:8])
            WA:      wr_addr = shbits[7:0];
            WD:      mem[wr_addr] = shbits[7:0];
            RA:      rd_addr = shbits[7:0];
            default: ;
          endcase
        end
        highcnt = 0;
      end
      highcnt++;
      lowcnt = 0;
    end
  end

  // ---------------- checking helpers ----------------
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] d);
    wait_ready();
    req_cmd   = c;
    req_data  = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frm_len.size() < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("frame_timeout", 32'(frm_len.size() >= target), 32'd1);
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [7:0]  data;
    int          len;
    logic [31:0] bits;
    int          pulses;
    logic [7:0]  rsp;
  } vec_t;

  vec_t vecs[12];
  vec_t b2b[4];

  initial begin
    int base_f, base_r;
    vecs[0]  = '{WA, 8'h3C, 11, 32'h0000_003C, 0, 8'h00};
    vecs[1]  = '{WD, 8'hA5, 11, 32'h0000_01A5, 0, 8'h00};
    vecs[2]  = '{RA, 8'h3C, 11, 32'h0000_063C, 0, 8'h00};
    vecs[3]  = '{RD, 8'h5A, 21, 32'h001C_0000, 1, 8'hA5};
    vecs[4]  = '{WA, 8'h01, 11, 32'h0000_0001, 0, 8'hA5};
    vecs[5]  = '{WD, 8'hFF, 11, 32'h0000_01FF, 0, 8'hA5};
    vecs[6]  = '{RA, 8'h01, 11, 32'h0000_0601, 0, 8'hA5};
    vecs[7]  = '{RD, 8'h00, 21, 32'h001C_0000, 1, 8'hFF};
    vecs[8]  = '{WA, 8'h02, 11, 32'h0000_0002, 0, 8'hFF};
    vecs[9]  = '{WD, 8'h00, 11, 32'h0000_0100, 0, 8'hFF};
    vecs[10] = '{RA, 8'h02, 11, 32'h0000_0602, 0, 8'hFF};
    vecs[11] = '{RD, 8'hC3, 21, 32'h001C_0000, 1, 8'h00};
    b2b[0]   = '{WA, 8'h81, 11, 32'h0000_0081, 0, 8'h00};
    b2b[1]   = '{WD, 8'h7E, 11, 32'h0000_017E, 0, 8'h00};
    b2b[2]   = '{RA, 8'h81, 11, 32'h0000_0681, 0, 8'h00};
    b2b[3]   = '{RD, 8'h00, 21, 32'h001C_0000, 1, 8'h7E};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ss_n", 32'(SS_n), 32'd1);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;

    // reset in the middle of a WR_ADDR shift
    send(WA, 8'h3C);
    repeat (5) @(negedge clk);
    chk("mid_ss_low", 32'(SS_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ss_n", 32'(SS_n), 32'd1);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_mosi", 32'(MOSI), 32'd0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    base_f = frm_len.size();
    base_r = rsp_cnt;
    repeat (15) @(negedge clk);
    chk("mid_rst_no_frame", 32'(frm_len.size()), 32'(base_f));
    chk("mid_rst_no_rsp", 32'(rsp_cnt), 32'(base_r));
    chk("mid_rst_ss_idle", 32'(SS_n), 32'd1);

    // table of single commands with a RAM-backed slave
    foreach (vecs[i]) begin
      base_f = frm_len.size();
      base_r = rsp_cnt;
      send(vecs[i].cmd, vecs[i].data);
      wait_frames(base_f + 1);
      repeat (3) @(negedge clk);
      if (frm_len.size() > base_f) begin
        chk($sformatf("v%0d_len", i), 32'(frm_len[base_f]), 32'(vecs[i].len));
        chk($sformatf("v%0d_bits", i), frm_bits[base_f], vecs[i].bits);
      end
      chk($sformatf("v%0d_pulses", i), 32'(rsp_cnt - base_r), 32'(vecs[i].pulses));
      chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].rsp));
      chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
    end

    // request during busy is dropped; in-flight frame untouched
    base_f = frm_len.size();
    send(RA, 8'h55);
    repeat (2) @(negedge clk);
    req_cmd = WA; req_data = 8'h10; req_valid = 1'b1;
    repeat (6) @(negedge clk);
    chk("busy_ready_low", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    wait_frames(base_f + 1);
    repeat (20) @(negedge clk);
    chk("busy_frames", 32'(frm_len.size()), 32'(base_f + 1));
    if (frm_len.size() > base_f) chk("busy_bits", frm_bits[base_f], 32'h0000_0655);

    // req_valid held high across four back-to-back commands
    base_f = frm_len.size();
    base_r = rsp_cnt;
    foreach (b2b[i]) begin
      wait_ready();
      req_cmd = b2b[i].cmd; req_data = b2b[i].data; req_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    wait_frames(base_f + 4);
    repeat (20) @(negedge clk);
    chk("b2b_frames", 32'(frm_len.size()), 32'(base_f + 4));
    for (int i = 0; i < 4; i++) begin
      if (frm_len.size() > base_f + i) begin
        chk($sformatf("b2b%0d_len", i), 32'(frm_len[base_f+i]), 32'(b2b[i].len));
        chk($sformatf("b2b%0d_bits", i), frm_bits[base_f+i], b2b[i].bits);
        if (i > 0) chk($sformatf("b2b%0d_gap", i), 32'(frm_gap[base_f+i] >= GAP), 32'd1);
      end
    end
    chk("b2b_pulses", 32'(rsp_cnt - base_r), 32'd1);
    chk("b2b_rsp_data", 32'(rsp_data), 32'h7E);
    chk("ready_low_in_frames", 32'(bad_ready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
